decrement_then_stop: RTL and testbench

// - Down-counting companion to the saturating up-counter: loads a start value, steps down by step_i per

---
 rtl/decrement_then_stop_pkg.sv | 12 +
 rtl/decrement_then_stop_sat_sub.sv | 23 ++
 rtl/decrement_then_stop.sv | 108 ++++++++++
 tb/tb_decrement_then_stop.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decrement_then_stop_pkg.sv
// Shared counter types: state encoding used by the countdown and its sibling counters.
// Latency: n/a (types only).
// Backpressure: n/a.
package decrement_then_stop_pkg;

   typedef enum logic [1:0] {
      CNT_IDLE = 2'd0,
      CNT_RUN  = 2'd1,
      CNT_DONE = 2'd2
   } cnt_state_e;

endpackage

// File: rtl/decrement_then_stop_sat_sub.sv
// Floor-clamped subtractor: result = max(a - b, floor), flags when the floor was reached.
// Latency: purely combinational.
// Backpressure: none.
module sat_sub #(
   parameter int Bits = 8
) (
   input  logic [Bits-1:0] a,
   input  logic [Bits-1:0] b,
   input  logic [Bits-1:0] floor_val,
   output logic [Bits-1:0] result,
   output logic            hit_floor
);

   logic [Bits:0] diff;

   // One extra bit catches the borrow so a small a never wraps to a large value.
   always_comb begin
      diff      = {1'b0, a} - {1'b0, b};
      hit_floor = diff[Bits] || (diff[Bits-1:0] <= floor_val);
      result    = hit_floor ? floor_val : diff[Bits-1:0];
   end

endmodule

// File: rtl/decrement_then_stop.sv
// Countdown from a loaded start value to an end value by a captured step; done pulses on arrival.
// Latency: start takes effect on the next edge; each enabled RUN edge moves count one step.
// Backpressure: en_i low holds the count while busy; a new start always wins over en_i.
module decrement_then_stop
   import decrement_then_stop_pkg::*;
#(
   parameter int Bits = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            en_i,
   input  logic [Bits-1:0] start_val_i,
   input  logic [Bits-1:0] end_val_i,
   input  logic [Bits-1:0] step_i,
   output logic [Bits-1:0] count_o,
   output logic            busy_o,
   output logic            last_o,
   output logic            done_o,
   input  logic            assert_on_i
);

   cnt_state_e      state_q, state_d;
   logic [Bits-1:0] count_q, count_d;
   logic [Bits-1:0] end_q, end_d;
   logic [Bits-1:0] step_q, step_d;
   logic [Bits-1:0] sub_res;
   logic            sub_hit;
   logic [Bits-1:0] load_step;

   // The same subtractor feeds both the next count and last_o, so they cannot disagree.
   sat_sub #(.Bits(Bits)) u_sat_sub (
      .a         (count_q),
      .b         (step_q),
      .floor_val (end_q),
      .result    (sub_res),
      .hit_floor (sub_hit)
   );

   // A zero step would stall forever; treat it as one.
   assign load_step = (step_i == '0) ? Bits'(1) : step_i;

   // State, count and captured end/step registers; reset returns to IDLE with no done pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CNT_IDLE;
         count_q <= '0;
         end_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         end_q   <= end_d;
         step_q  <= step_d;
      end
   end

   // Next state and datapath: start reloads from any state, otherwise RUN steps toward end_q.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      end_d   = end_q;
      step_d  = step_q;
      if (start_i) begin
         end_d  = end_val_i;
         step_d = load_step;
         if (start_val_i <= end_val_i) begin
            count_d = end_val_i;
            state_d = CNT_DONE;
         end else begin
            count_d = start_val_i;
            state_d = CNT_RUN;
         end
      end else begin
         case (state_q)
            CNT_RUN: begin
               if (en_i) begin
                  count_d = sub_res;
                  if (sub_hit) begin
                     state_d = CNT_DONE;
                  end
               end
            end
            CNT_DONE: state_d = CNT_IDLE;
            CNT_IDLE: state_d = CNT_IDLE;
            default:  state_d = CNT_IDLE;
         endcase
      end
   end

   // Outputs decoded from the current state; last_o ignores en_i by design.
   always_comb begin
      busy_o = (state_q == CNT_RUN);
      done_o = (state_q == CNT_DONE);
      last_o = (state_q == CNT_RUN) && sub_hit;
   end

   assign count_o = count_q;

   // Flag a start whose end value lies above the start value.
   always_ff @(posedge clk_i) begin
      if (!rst_i && assert_on_i && start_i) begin
         assert (end_val_i <= start_val_i)
            else $error("decrement_then_stop: end_val_i=%h above start_val_i=%h", end_val_i, start_val_i);
      end
   end

endmodule

// File: tb/tb_decrement_then_stop.sv
// Directed and random bench for decrement_then_stop against an integer reference model.
// Latency: inputs applied after an edge, outputs compared 1 time unit after the next edge.
// Backpressure: en_i toggled and randomised to exercise hold behaviour.
module tb_decrement_then_stop;

   logic       clk_i;
   logic       rst_i;
   logic       start_i;
   logic       en_i;
   logic [7:0] start_val_i;
   logic [7:0] end_val_i;
   logic [7:0] step_i;
   logic [7:0] count_o;
   logic       busy_o;
   logic       last_o;
   logic       done_o;
   logic       assert_on_i;

   int n_err;
   int n_chk;

   // Reference model: plain integers, no borrow tricks.
   int m_count;
   int m_end;
   int m_step;
   bit m_busy;
   bit m_done;

   decrement_then_stop #(.Bits(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .en_i        (en_i),
      .start_val_i (start_val_i),
      .end_val_i   (end_val_i),
      .step_i      (step_i),
      .count_o     (count_o),
      .busy_o      (busy_o),
      .last_o      (last_o),
      .done_o      (done_o),
      .assert_on_i (assert_on_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
         end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
         end
   endtask

   task automatic model_reset();
      m_count = 0;
      m_end   = 0;
      m_step  = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
   endtask

   // Goal: count walks from start toward end by step, landing exactly on end.
   task automatic model_step(input bit s, input bit e, input int sv, input int ev, input int st);
      if (s) begin
         m_end  = ev;
         m_step = (st == 0) ? 1 : st;
         if (sv <= ev) begin
            m_count = ev;
            m_busy  = 1'b0;
            m_done  = 1'b1;
         end else begin
            m_count = sv;
            m_busy  = 1'b1;
            m_done  = 1'b0;
         end
      end else if (m_busy && e) begin
         if (m_count - m_step <= m_end) begin
            m_count = m_end;
            m_busy  = 1'b0;
            m_done  = 1'b1;
         end else begin
            m_count = m_count - m_step;
            m_done  = 1'b0;
         end
      end else begin
         m_done = 1'b0;
      end
   endtask

   task automatic check_all(input string tag);
      check8({tag, ".count"}, count_o, 8'(m_count));
      check1({tag, ".busy"}, busy_o, m_busy);
      check1({tag, ".done"}, done_o, m_done);
      check1({tag, ".last"}, last_o, m_busy && (m_count - m_step <= m_end));
   endtask

   // Apply one cycle of inputs, advance model and DUT together, compare.
   task automatic do_cycle(input string tag, input bit s, input bit e,
                           input logic [7:0] sv, input logic [7:0] ev, input logic [7:0] st);
      start_i     = s;
      en_i        = e;
      start_val_i = sv;
      end_val_i   = ev;
      step_i      = st;
      @(posedge clk_i);
      model_step(s, e, int'(sv), int'(ev), int'(st));
      #1;
      check_all(tag);
   endtask

   // Idle/run cycle with junk on the data inputs, which must be ignored without a start.
   task automatic run_cycle(input string tag, input bit e);
      do_cycle(tag, 1'b0, e, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
   endtask

   // Bounded wait for completion with en_i held high.
   task automatic run_to_done(input string tag, input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < max_cycles && !seen; k++) begin
         run_cycle(tag, 1'b1);
         if (done_o === 1'b1) seen = 1'b1;
      end
      check1({tag, ".done_seen"}, seen, 1'b1);
   endtask

   initial begin
      n_err       = 0;
      n_chk       = 0;
      rst_i       = 1'b1;
      start_i     = 1'b0;
      en_i        = 1'b0;
      start_val_i = '0;
      end_val_i   = '0;
      step_i      = '0;
      assert_on_i = 1'b1;
      model_reset();

      // Reset state
      #12;
      check_all("reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Unit step: 10 down to 3
      do_cycle("unit_load", 1'b1, 1'b1, 8'd10, 8'd3, 8'd1);
      check8("unit_load_const", count_o, 8'd10);
      repeat (6) run_cycle("unit_run", 1'b1);
      check8("unit_at4_count", count_o, 8'd4);
      check1("unit_at4_last", last_o, 1'b1);
      run_cycle("unit_end", 1'b1);
      check8("unit_end_count", count_o, 8'd3);
      check1("unit_end_done", done_o, 1'b1);
      run_cycle("unit_idle", 1'b1);
      check1("unit_idle_done", done_o, 1'b0);

      // Clamp: 20, 13, 6, 5
      do_cycle("clamp_load", 1'b1, 1'b1, 8'd20, 8'd5, 8'd7);
      run_cycle("clamp_run", 1'b1);
      check8("clamp_13", count_o, 8'd13);
      run_cycle("clamp_run", 1'b1);
      check8("clamp_6", count_o, 8'd6);
      run_cycle("clamp_run", 1'b1);
      check8("clamp_5", count_o, 8'd5);
      check1("clamp_done", done_o, 1'b1);
      repeat (3) run_cycle("clamp_idle", 1'b1);
      check8("clamp_hold", count_o, 8'd5);

      // Large step from a small count must not wrap
      do_cycle("uflow_load", 1'b1, 1'b1, 8'd3, 8'd0, 8'd200);
      run_cycle("uflow_run", 1'b1);
      check8("uflow_zero", count_o, 8'd0);
      check1("uflow_done", done_o, 1'b1);

      // Zero step behaves as one
      do_cycle("step0_load", 1'b1, 1'b1, 8'd2, 8'd0, 8'd0);
      run_cycle("step0_run", 1'b1);
      check8("step0_1", count_o, 8'd1);
      run_cycle("step0_run", 1'b1);
      check8("step0_0", count_o, 8'd0);
      run_cycle("step0_idle", 1'b0);

      // Enable gating
      do_cycle("gate_load", 1'b1, 1'b0, 8'd50, 8'd40, 8'd1);
      for (int i = 0; i < 22; i++) run_cycle("gate_run", (i % 2) == 0);
      check8("gate_final", count_o, 8'd40);

      // Restart mid-run at count 7
      do_cycle("rst_load", 1'b1, 1'b1, 8'd12, 8'd2, 8'd1);
      repeat (5) run_cycle("rst_run", 1'b1);
      check8("restart_at7", count_o, 8'd7);
      do_cycle("restart", 1'b1, 1'b1, 8'd30, 8'd20, 8'd1);
      check8("restart_count", count_o, 8'd30);
      check1("restart_done", done_o, 1'b0);
      check1("restart_busy", busy_o, 1'b1);
      run_to_done("restart_finish", 40);
      run_cycle("restart_idle", 1'b0);

      // Start equal to end goes straight to DONE
      do_cycle("eq_load", 1'b1, 1'b0, 8'd5, 8'd5, 8'd3);
      check1("eq_done", done_o, 1'b1);
      check1("eq_busy", busy_o, 1'b0);
      run_cycle("eq_idle", 1'b0);

      // End above start: clamps to end; checker silenced for this deliberate misuse
      assert_on_i = 1'b0;
      do_cycle("inv_load", 1'b1, 1'b0, 8'd4, 8'd9, 8'd1);
      check8("inv_count", count_o, 8'd9);
      assert_on_i = 1'b1;
      run_cycle("inv_idle", 1'b0);

      // Asynchronous reset mid-run
      do_cycle("arst_load", 1'b1, 1'b1, 8'd100, 8'd0, 8'd1);
      repeat (3) run_cycle("arst_run", 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      model_reset();
      check8("arst_count", count_o, 8'd0);
      check1("arst_busy", busy_o, 1'b0);
      check1("arst_done", done_o, 1'b0);
      @(posedge clk_i);
      #1;
      check_all("arst_held");
      rst_i = 1'b0;
      run_cycle("arst_after", 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         bit         s;
         logic [7:0] sv;
         logic [7:0] ev;
         logic [7:0] st;
         s  = ($urandom_range(0, 6) == 0);
         sv = 8'($urandom_range(0, 255));
         ev = 8'($urandom_range(0, int'(sv)));
         st = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
         do_cycle("rand", s, 1'($urandom_range(0, 1)), sv, ev, st);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
